// File: rtl/phoenix_vc_buffer.sv
// Multi-lane router input buffer: NUM_VC circular FIFOs sharing one link, each
// with a request/send FSM that counts packet length from the size flit.
module phoenix_vc_buffer #(
  parameter int FLIT_W = 16,
  parameter int DEPTH  = 8,
  parameter int NUM_VC = 2,
  localparam int LW    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rx,
  input  logic [LW-1:0]            lane_in,
  input  logic [FLIT_W-1:0]        data_in,
  output logic [NUM_VC-1:0]        credit_o,
  output logic [NUM_VC-1:0]        h,
  input  logic [NUM_VC-1:0]        ack_h,
  output logic [NUM_VC-1:0]        data_av,
  input  logic [NUM_VC-1:0]        data_ack,
  output logic [NUM_VC-1:0]        sender,
  output logic [NUM_VC*FLIT_W-1:0] data,
  output logic [NUM_VC-1:0]        ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  localparam logic [0:0] REQ_ROUTING = 1'b0;
  localparam logic [0:0] SEND_DATA   = 1'b1;

  localparam logic [1:0] IDX_HEADER  = 2'd0;
  localparam logic [1:0] IDX_SIZE    = 2'd1;
  localparam logic [1:0] IDX_PAYLOAD = 2'd2;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_lane
    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [PW:0]       count;
    logic [0:0]        state;
    logic [1:0]        flit_idx;
    logic [FLIT_W-1:0] remaining;
    logic              ovf_q;

    logic              empty;
    logic              full;
    logic              hit;
    logic              pop;
    logic              push;
    logic              drop;
    logic [FLIT_W-1:0] head;
    logic              pkt_done;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign head  = mem[rd_ptr];

    // Lane indices that match no generated lane are silently ignored.
    assign hit  = rx && (lane_in == LW'(v));
    assign pop  = data_ack[v] && data_av[v];
    assign push = hit && (!full || pop);
    assign drop = hit && full && !pop;

    assign h[v]        = (state == REQ_ROUTING) && !empty;
    assign data_av[v]  = (state == SEND_DATA) && !empty;
    assign sender[v]   = (state == SEND_DATA);
    assign credit_o[v] = !full || pop;
    assign ovf[v]      = ovf_q;
    assign data[v*FLIT_W +: FLIT_W] = empty ? '0 : head;

    always_comb begin
      pkt_done = 1'b0;
      if (pop) begin
        case (flit_idx)
          IDX_SIZE:    pkt_done = (head == '0);
          IDX_PAYLOAD: pkt_done = (remaining == FLIT_W'(1));
          default:     pkt_done = 1'b0;
        endcase
      end
    end

    // Storage is deliberately left unreset; only pointers and counts define validity.
    always_ff @(posedge clock) begin
      if (push) begin
        mem[wr_ptr] <= data_in;
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        ovf_q  <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push && !pop) begin
          count <= count + 1'b1;
        end else if (pop && !push) begin
          count <= count - 1'b1;
        end
        if (drop) begin
          ovf_q <= 1'b1;
        end
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        state     <= REQ_ROUTING;
        flit_idx  <= IDX_HEADER;
        remaining <= '0;
      end else begin
        case (state)
          REQ_ROUTING: begin
            if (ack_h[v]) begin
              state     <= SEND_DATA;
              flit_idx  <= IDX_HEADER;
              remaining <= '0;
            end
          end
          SEND_DATA: begin
            if (pop) begin
              case (flit_idx)
                IDX_HEADER: flit_idx <= IDX_SIZE;
                IDX_SIZE: begin
                  remaining <= head;
                  flit_idx  <= IDX_PAYLOAD;
                end
                default: remaining <= remaining - 1'b1;
              endcase
            end
            if (pkt_done) begin
              state <= REQ_ROUTING;
            end
          end
          default: state <= REQ_ROUTING;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phoenix_vc_buffer.sv
// Bench for phoenix_vc_buffer: directed packet scenarios plus a random phase,
// all outputs compared every cycle against a queue-based packet model.
module tb_phoenix_vc_buffer;

  localparam int FLIT_W = 16;
  localparam int DEPTH  = 8;
  localparam int NUM_VC = 2;

  logic              clock;
  logic              reset;
  logic              rx;
  logic [0:0]        lane_in;
  logic [15:0]       data_in;
  logic [1:0]        credit_o;
  logic [1:0]        h;
  logic [1:0]        ack_h;
  logic [1:0]        data_av;
  logic [1:0]        data_ack;
  logic [1:0]        sender;
  logic [31:0]       data;
  logic [1:0]        ovf;

  int errors = 0;
  int checks = 0;

  // Model: per-lane flit queue, send mode, flits popped in the current packet
  // and total packet length once the size flit has been seen (-1 = unknown).
  logic [15:0] q [NUM_VC][$];
  bit          snd  [NUM_VC];
  int          pcnt [NUM_VC];
  int          plen [NUM_VC];
  bit          movf [NUM_VC];

  phoenix_vc_buffer #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .NUM_VC(NUM_VC)) dut (
    .clock(clock), .reset(reset), .rx(rx), .lane_in(lane_in), .data_in(data_in),
    .credit_o(credit_o), .h(h), .ack_h(ack_h), .data_av(data_av),
    .data_ack(data_ack), .sender(sender), .data(data), .ovf(ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int v = 0; v < NUM_VC; v++) begin
      q[v].delete();
      snd[v]  = 1'b0;
      pcnt[v] = 0;
      plen[v] = -1;
      movf[v] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; rx = 1'b0; lane_in = '0; data_in = '0; ack_h = '0; data_ack = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic step(input bit rxi, input int ln, input logic [15:0] d,
                      input logic [1:0] ah, input logic [1:0] da);
    logic [1:0]  e_h, e_av, e_snd, e_cr, e_ovf, e_pop;
    logic [31:0] e_data;
    logic [15:0] f;
    rx = rxi; lane_in = ln[0]; data_in = d; ack_h = ah; data_ack = da;
    #1;
    e_data = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      e_h[v]   = !snd[v] && (q[v].size() > 0);
      e_av[v]  = snd[v] && (q[v].size() > 0);
      e_snd[v] = snd[v];
      e_pop[v] = da[v] && e_av[v];
      e_cr[v]  = (q[v].size() != DEPTH) || e_pop[v];
      e_ovf[v] = movf[v];
      if (q[v].size() > 0) e_data[v*16 +: 16] = q[v][0];
    end
    chk("credit_o", {30'd0, credit_o}, {30'd0, e_cr});
    chk("h",        {30'd0, h},        {30'd0, e_h});
    chk("data_av",  {30'd0, data_av},  {30'd0, e_av});
    chk("sender",   {30'd0, sender},   {30'd0, e_snd});
    chk("ovf",      {30'd0, ovf},      {30'd0, e_ovf});
    chk("data",     data,              e_data);
    @(posedge clock);
    for (int v = 0; v < NUM_VC; v++) begin
      bit was_snd;
      was_snd = snd[v];
      if (e_pop[v]) begin
        f = q[v].pop_front();
        pcnt[v]++;
        if (pcnt[v] == 2) plen[v] = int'(f) + 2;
        if (pcnt[v] >= 2 && pcnt[v] == plen[v]) snd[v] = 1'b0;
      end
      if (rxi && ln == v) begin
        if (q[v].size() < DEPTH) q[v].push_back(d);
        else movf[v] = 1'b1;
      end
      if (!was_snd && ah[v]) begin
        snd[v]  = 1'b1;
        pcnt[v] = 0;
        plen[v] = -1;
      end
    end
    #1;
  endtask

  task automatic push(input int ln, input logic [15:0] d);
    step(1'b1, ln, d, 2'b00, 2'b00);
  endtask

  task automatic idle(input logic [1:0] ah, input logic [1:0] da, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 16'h0, ah, da);
  endtask

  initial begin
    reset = 1'b1; rx = 1'b0; lane_in = '0; data_in = '0; ack_h = '0; data_ack = '0;
    model_clear();
    @(posedge clock); #1;
    do_reset();

    // Reset state, first push visibility
    idle(2'b00, 2'b00, 1);
    push(0, 16'h0011);
    idle(2'b00, 2'b00, 1);

    // Full 5-flit packet on lane 0
    push(0, 16'h0003); push(0, 16'h00A1); push(0, 16'h00B2); push(0, 16'h00C3);
    idle(2'b01, 2'b01, 1);
    idle(2'b00, 2'b01, 6);
    chk("pkt5_sender_done", {31'd0, sender[0]}, 32'd0);
    chk("pkt5_h_done",      {31'd0, h[0]},      32'd0);

    // Size-0 packet followed by the next header
    push(0, 16'h0022); push(0, 16'h0000); push(0, 16'h0033);
    idle(2'b01, 2'b00, 1);
    idle(2'b00, 2'b01, 3);
    chk("size0_h_next",    {31'd0, h[0]},    32'd1);
    chk("size0_data_next", {16'd0, data[15:0]}, 32'h0033);
    do_reset();

    // Fill lane 1, overflow, then push+pop while full
    for (int i = 0; i < DEPTH; i++) push(1, 16'h0100 + 16'(i));
    chk("full_credit", {30'd0, credit_o}, 32'b01);
    push(1, 16'h01FF);
    chk("ovf_set", {30'd0, ovf}, 32'b10);
    idle(2'b10, 2'b00, 1);
    step(1'b1, 1, 16'h0155, 2'b00, 2'b10);
    idle(2'b00, 2'b00, 1);
    do_reset();

    // Interleaved arrivals, both lanes granted and draining
    idle(2'b11, 2'b11, 1);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] f0, f1;
      f0 = (i == 0) ? 16'h00A0 : (i == 1) ? 16'h0002 : 16'h0A00 + 16'(i);
      f1 = (i == 0) ? 16'h00B0 : (i == 1) ? 16'h0002 : 16'h0B00 + 16'(i);
      step(1'b1, 0, f0, 2'b00, 2'b11);
      step(1'b1, 1, f1, 2'b00, 2'b11);
    end
    idle(2'b00, 2'b11, 3);
    chk("intlv_idle", {28'd0, sender, h}, 32'd0);

    // Reset in the middle of a packet, then a clean packet
    push(0, 16'h0044); push(0, 16'h0003); push(0, 16'h0001); push(0, 16'h0002); push(0, 16'h0003);
    idle(2'b01, 2'b00, 1);
    idle(2'b00, 2'b01, 2);
    do_reset();
    idle(2'b00, 2'b00, 1);
    chk("midrst_credit", {30'd0, credit_o}, 32'b11);
    push(0, 16'h0055); push(0, 16'h0001); push(0, 16'h0077);
    idle(2'b01, 2'b01, 1);
    idle(2'b00, 2'b01, 4);

    // Random traffic with small header/size values so packets terminate
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 1)),
           16'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
